// File: rtl/frame_swap_controller.sv
// Double-buffer arbiter between a renderer and a scan-out engine sharing one framebuffer RAM.
// Renders land in the back buffer, scans read the front buffer, and buffers swap only at vblank.
module frame_swap_controller #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              new_frame,
  input  logic              render_done,
  output logic              render_ack,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic              wr_en,
  input  logic [2:0]        wr_color_in,
  input  logic [9:0]        rd_x,
  input  logic [8:0]        rd_y,
  output logic [ADDR_W:0]   ram_wr_addr,
  output logic [2:0]        ram_wr_data,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_rd_addr,
  output logic              rd_valid,
  output logic              front_sel,
  output logic [CNT_W-1:0]  repeat_count,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {
    ST_RENDER    = 2'd0,
    ST_WAIT_SWAP = 2'd1,
    ST_ACK       = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               front_sel_q, front_sel_d;
  logic               render_ack_q, render_ack_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W:0]    ram_wr_addr_q, ram_wr_addr_d;
  logic [2:0]         ram_wr_data_q, ram_wr_data_d;
  logic [ADDR_W:0]    ram_rd_addr_q, ram_rd_addr_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   repeat_count_q, repeat_count_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;

  logic               swap;
  logic               repeat_inc;
  logic               wr_in_range;
  logic               wr_legal;
  logic               drop_inc;
  logic               rd_in_range;

  // Full-width linear address, truncated to the per-buffer address width.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [8:0] y, input logic [9:0] x);
    return ADDR_W'(int'(y) * H_RES + int'(x));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap        = 1'b0;
    repeat_inc  = 1'b0;
    case (state_q)
      ST_RENDER: begin
        if (render_done && new_frame) begin
          swap    = 1'b1;
          state_d = ST_ACK;
        end else if (render_done) begin
          state_d = ST_WAIT_SWAP;
        end else if (new_frame) begin
          repeat_inc = 1'b1;
        end
      end
      ST_WAIT_SWAP: begin
        if (new_frame) begin
          swap    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_RENDER;
        if (new_frame) repeat_inc = 1'b1;
      end
      default: state_d = ST_RENDER;
    endcase
    if (swap) front_sel_d = ~front_sel_q;
    render_ack_d = swap;
  end

  // A write coinciding with a swap would land in the buffer about to go on screen, so it is dropped.
  always_comb begin
    wr_in_range   = (int'(wr_x) < H_RES) && (int'(wr_y) < V_RES);
    wr_legal      = wr_en && wr_in_range && (state_q == ST_RENDER) && !swap;
    drop_inc      = wr_en && !wr_legal;
    ram_we_d      = wr_legal;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    if (wr_legal) begin
      ram_wr_addr_d = {~front_sel_q, lin_addr(wr_y, wr_x)};
      ram_wr_data_d = wr_color_in;
    end
    drop_count_d   = sat_inc(drop_count_q, drop_inc);
    repeat_count_d = sat_inc(repeat_count_q, repeat_inc);
  end

  always_comb begin
    rd_in_range   = (int'(rd_x) < H_RES) && (int'(rd_y) < V_RES);
    rd_valid_d    = rd_in_range;
    ram_rd_addr_d = {front_sel_q, rd_in_range ? lin_addr(rd_y, rd_x) : '0};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_RENDER;
      front_sel_q    <= 1'b0;
      render_ack_q   <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_wr_addr_q  <= '0;
      ram_wr_data_q  <= '0;
      ram_rd_addr_q  <= '0;
      rd_valid_q     <= 1'b0;
      repeat_count_q <= '0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      render_ack_q   <= render_ack_d;
      ram_we_q       <= ram_we_d;
      ram_wr_addr_q  <= ram_wr_addr_d;
      ram_wr_data_q  <= ram_wr_data_d;
      ram_rd_addr_q  <= ram_rd_addr_d;
      rd_valid_q     <= rd_valid_d;
      repeat_count_q <= repeat_count_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign render_ack   = render_ack_q;
  assign ram_we       = ram_we_q;
  assign ram_wr_addr  = ram_wr_addr_q;
  assign ram_wr_data  = ram_wr_data_q;
  assign ram_rd_addr  = ram_rd_addr_q;
  assign rd_valid     = rd_valid_q;
  assign front_sel    = front_sel_q;
  assign repeat_count = repeat_count_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_frame_swap_controller.sv
// Scoreboard bench for frame_swap_controller: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the swap/drop/repeat rules.
module tb_frame_swap_controller;

  logic        Clk = 1'b0;
  logic        Reset, new_frame, render_done, wr_en;
  logic        render_ack, ram_we, rd_valid, front_sel;
  logic [9:0]  wr_x, rd_x;
  logic [8:0]  wr_y, rd_y;
  logic [2:0]  wr_color_in, ram_wr_data;
  logic [17:0] ram_wr_addr, ram_rd_addr;
  logic [7:0]  repeat_count, drop_count;

  frame_swap_controller dut (
    .Clk(Clk), .Reset(Reset), .new_frame(new_frame), .render_done(render_done),
    .render_ack(render_ack), .wr_x(wr_x), .wr_y(wr_y), .wr_en(wr_en),
    .wr_color_in(wr_color_in), .rd_x(rd_x), .rd_y(rd_y), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_we(ram_we), .ram_rd_addr(ram_rd_addr),
    .rd_valid(rd_valid), .front_sel(front_sel), .repeat_count(repeat_count),
    .drop_count(drop_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic        chk_wa;
    logic [17:0] wa;
    logic [2:0]  wd;
    logic [17:0] ra;
    logic        rv;
    logic        ack;
    logic        fs;
    logic [7:0]  rc;
    logic [7:0]  dc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: buffer ownership and bookkeeping after each clock edge.
  logic m_front, m_done_seen, m_in_ack;
  int   m_rep, m_drop;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and record what the next rising edge must produce.
  task automatic tick(input logic rst, input logic nf, input logic rdn, input logic we,
                      input logic [9:0] wx, input logic [8:0] wy, input logic [2:0] c,
                      input logic [9:0] rx, input logic [8:0] ry);
    exp_t e;
    logic swp, wr_ok, rd_ok;
    int   wl, rl;
    @(negedge Clk);
    Reset = rst; new_frame = nf; render_done = rdn; wr_en = we;
    wr_x = wx; wr_y = wy; wr_color_in = c; rd_x = rx; rd_y = ry;
    if (rst) begin
      m_front = 0; m_done_seen = 0; m_in_ack = 0; m_rep = 0; m_drop = 0;
      e = '{we:0, chk_wa:1, wa:0, wd:0, ra:0, rv:0, ack:0, fs:0, rc:0, dc:0};
    end else begin
      wl = int'(wy) * 320 + int'(wx);
      rl = int'(ry) * 320 + int'(rx);
      swp   = nf && !m_in_ack && (m_done_seen || rdn);
      wr_ok = we && wx < 320 && wy < 240 && !m_in_ack && !m_done_seen && !swp;
      rd_ok = rx < 320 && ry < 240;
      e.we = wr_ok; e.chk_wa = wr_ok;
      e.wa = {~m_front, wl[16:0]}; e.wd = c;
      e.ra = rd_ok ? {m_front, rl[16:0]} : {m_front, 17'd0};
      e.rv = rd_ok; e.ack = swp;
      if (we && !wr_ok && m_drop < 255) m_drop++;
      if (nf && !swp && m_rep < 255) m_rep++;
      m_done_seen = (m_in_ack || swp) ? 1'b0 : (m_done_seen | rdn);
      m_in_ack = swp;
      if (swp) m_front = ~m_front;
      e.fs = m_front; e.rc = 8'(m_rep); e.dc = 8'(m_drop);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic rdn);
    tick(0, 0, rdn, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge Clk); #2;
  endtask

  // Monitor: every rising edge with an outstanding expectation is compared field by field.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ram_we", int'(ram_we), int'(e.we));
      if (e.chk_wa) begin
        chk("ram_wr_addr", int'(ram_wr_addr), int'(e.wa));
        chk("ram_wr_data", int'(ram_wr_data), int'(e.wd));
      end
      chk("ram_rd_addr", int'(ram_rd_addr), int'(e.ra));
      chk("rd_valid", int'(rd_valid), int'(e.rv));
      chk("render_ack", int'(render_ack), int'(e.ack));
      chk("front_sel", int'(front_sel), int'(e.fs));
      chk("repeat_count", int'(repeat_count), int'(e.rc));
      chk("drop_count", int'(drop_count), int'(e.dc));
    end
  end

  initial begin
    logic rdn;
    logic [9:0] wx, rx;
    logic [8:0] wy, ry;
    Reset = 1; new_frame = 0; render_done = 0; wr_en = 0;
    wr_x = 0; wr_y = 0; wr_color_in = 0; rd_x = 0; rd_y = 0;
    m_front = 0; m_done_seen = 0; m_in_ack = 0; m_rep = 0; m_drop = 0;

    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("reset front_sel", int'(front_sel), 0);
    chk("reset ram_we", int'(ram_we), 0);
    chk("reset counters", int'(drop_count) + int'(repeat_count), 0);

    tick(0, 0, 0, 1, 10'd5, 9'd2, 3'd6, 0, 0);
    settle();
    chk("first write addr", int'(ram_wr_addr), int'({1'b1, 17'd645}));
    chk("first write data", int'(ram_wr_data), 6);
    chk("first write we", int'(ram_we), 1);

    tick(0, 0, 0, 0, 0, 0, 0, 10'd319, 9'd239);
    settle();
    chk("last pixel rd addr", int'(ram_rd_addr), 76799);
    chk("last pixel rd_valid", int'(rd_valid), 1);
    tick(0, 0, 0, 0, 0, 0, 0, 10'd320, 9'd239);
    settle();
    chk("oob rd addr", int'(ram_rd_addr), 0);
    chk("oob rd_valid", int'(rd_valid), 0);

    repeat (10) idle(1);
    tick(0, 1, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("swap front_sel", int'(front_sel), 1);
    chk("swap ack", int'(render_ack), 1);
    idle(0);
    settle();
    chk("ack one cycle", int'(render_ack), 0);

    tick(0, 1, 1, 1, 10'd1, 9'd1, 3'd3, 0, 0);
    settle();
    chk("immediate swap ack", int'(render_ack), 1);
    chk("immediate swap front", int'(front_sel), 0);
    chk("swap-cycle write dropped", int'(drop_count), 1);
    idle(0);

    repeat (3) begin
      tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(0);
    end
    settle();
    chk("repeat_count", int'(repeat_count), 3);
    chk("repeat front unchanged", int'(front_sel), 0);
    repeat (300) tick(0, 0, 0, 1, 10'd400, 9'd10, 3'd1, 0, 0);
    settle();
    chk("drop saturation", int'(drop_count), 255);

    repeat (3) idle(1);
    tick(1, 1, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("reset mid-wait front", int'(front_sel), 0);
    chk("reset mid-wait ack", int'(render_ack), 0);
    chk("reset mid-wait drops", int'(drop_count), 0);
    idle(0);

    rdn = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!rdn) rdn = ($urandom_range(0, 7) == 0);
      else if (m_in_ack && $urandom_range(0, 3) != 0) rdn = 0;
      wx = 10'($urandom_range(0, 340));
      wy = 9'($urandom_range(0, 255));
      rx = 10'($urandom_range(0, 340));
      ry = 9'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) wx = ($urandom_range(0, 1) != 0) ? 10'd319 : 10'd1023;
      if ($urandom_range(0, 15) == 0) ry = ($urandom_range(0, 1) != 0) ? 9'd239 : 9'd240;
      tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0), rdn,
           ($urandom_range(0, 3) != 0), wx, wy, 3'($urandom), rx, ry);
    end
    idle(0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
